drum_voice_arbiter: RTL and testbench

- Shares one tone/sample playback voice among the five drum channels (A..E) of the drum machine state machine.
- Inputs are the per-channel trigger pulses (Aout..Eout) and the playing flag from the sequencer.
- Latches each trigger as pending, picks one pending channel by round-robin, and starts the voice for a fixed note length.
- Inserts a silence gap between notes.

---
 rtl/drum_voice_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_drum_voice_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_voice_arbiter.sv
// drum_voice_arbiter
//
// Shares a single tone/sample playback voice among the five drum channels
// (A..E) of the drum machine sequencer. Incoming trigger pulses are latched as
// pending. A round-robin pick chooses one pending channel, which then owns the
// voice for NOTE_LEN cycles. A silence gap of GAP_LEN cycles follows each note.
//
// Optional build macro: KICK_PREEMPT_EN
//   When defined, channel 0 (kick) always wins arbitration in IDLE. It also
//   cuts short a note or gap that belongs to another channel.
//
// Parameters:
//   NOTE_LEN  cycles voice_on stays high per note (1..255)
//   GAP_LEN   silent cycles between notes (0..255)
//   CNT_W     width of the note/gap down-counter
//
// Ports:
//   Clk          system clock, all state on rising edge
//   Reset_n      asynchronous active-low reset
//   playing      sequencer running; low clears pending and aborts the note
//   req[4:0]     trigger pulses, bit0 = A .. bit4 = E
//   voice_ready  playback engine idle and able to accept a start
//   voice_start  one-cycle start strobe to the playback engine
//   voice_sel    channel index 0..4 of the current/last note
//   voice_on     high for the NOTE_LEN cycles of a note
//   pending      latched triggers not yet issued
//   drop         one-cycle pulse, trigger merged into an already pending one
module drum_voice_arbiter #(
  parameter int NOTE_LEN = 16,
  parameter int GAP_LEN  = 2,
  parameter int CNT_W    = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       playing,
  input  logic [4:0] req,
  input  logic       voice_ready,
  output logic       voice_start,
  output logic [2:0] voice_sel,
  output logic       voice_on,
  output logic [4:0] pending,
  output logic       drop
);

  // The ISSUE cycle is the first on-cycle, so HOLD covers NOTE_LEN-1 cycles.
  // The IDLE arbitration cycle is the last silent cycle, so GAP covers
  // GAP_LEN-1 cycles. Both counters hold "cycles left after this one".
  // This gives a note-to-note period of exactly NOTE_LEN + GAP_LEN cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = (NOTE_LEN >= 2) ? CNT_W'(NOTE_LEN - 2) : '0;
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_LEN  >= 2) ? CNT_W'(GAP_LEN  - 2) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       rr_last_reg;
  logic [2:0]       voice_sel_reg;
  logic [4:0]       pending_reg;
  logic             voice_start_reg;
  logic             voice_on_reg;
  logic             drop_reg;

  logic             in_issue;
  logic [2:0]       arb_base;
  logic [4:0]       issue_clr;
  logic [4:0]       pending_eff;
  logic [4:0]       pending_next;
  logic [4:0]       drop_hit;
  logic [2:0]       cand_idx [5];
  logic             winner_valid;
  logic [2:0]       winner_idx;
  logic             can_issue;
  logic             note_last;
  logic             preempt;

  assign in_issue = (state_reg == ST_ISSUE);

  // While in ISSUE, rr_last has not been updated yet. Arbitration in that
  // cycle (NOTE_LEN=1, GAP_LEN=0) must start after the channel being issued.
  assign arb_base = in_issue ? voice_sel_reg : rr_last_reg;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_chan
      logic [3:0] sum;
      // The channel issued this cycle loses its old pending bit. A fresh hit
      // on the same edge re-arms it as a new note and is not a drop.
      assign issue_clr[gi]    = in_issue && (voice_sel_reg == 3'(gi));
      assign pending_eff[gi]  = pending_reg[gi] & ~issue_clr[gi];
      assign pending_next[gi] = playing & (pending_eff[gi] | req[gi]);
      assign drop_hit[gi]     = playing & req[gi] & pending_eff[gi];
      // Search order slot gi holds channel (arb_base + gi + 1) mod 5.
      assign sum              = {1'b0, arb_base} + 4'(gi + 1);
      assign cand_idx[gi]     = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
    end
  endgenerate

  // Scan from the farthest slot back to the nearest one.
  // The nearest pending channel is written last, so it wins.
  always_comb begin
    winner_valid = 1'b0;
    winner_idx   = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (pending_eff[cand_idx[k]]) begin
        winner_valid = 1'b1;
        winner_idx   = cand_idx[k];
      end
    end
`ifdef KICK_PREEMPT_EN
    if (pending_eff[0]) begin
      winner_valid = 1'b1;
      winner_idx   = 3'd0;
    end
`endif
  end

  assign can_issue = playing & voice_ready & winner_valid;
  assign note_last = ((state_reg == ST_HOLD) && (cnt_reg == '0)) ||
                     (in_issue && (NOTE_LEN == 1));

`ifdef KICK_PREEMPT_EN
  assign preempt = playing & voice_ready & pending_reg[0] &
                   (voice_sel_reg != 3'd0) &
                   ((state_reg == ST_HOLD) || (state_reg == ST_GAP));
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      rr_last_reg     <= 3'd4;
      voice_sel_reg   <= 3'd0;
      pending_reg     <= 5'd0;
      voice_start_reg <= 1'b0;
      voice_on_reg    <= 1'b0;
      drop_reg        <= 1'b0;
    end else begin
      pending_reg     <= pending_next;
      drop_reg        <= |drop_hit;
      voice_start_reg <= 1'b0;
      if (!playing) begin
        state_reg    <= ST_IDLE;
        cnt_reg      <= '0;
        voice_on_reg <= 1'b0;
      end else if (preempt) begin
        state_reg       <= ST_ISSUE;
        voice_sel_reg   <= 3'd0;
        voice_start_reg <= 1'b1;
        voice_on_reg    <= 1'b1;
        cnt_reg         <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (can_issue) begin
              state_reg       <= ST_ISSUE;
              voice_sel_reg   <= winner_idx;
              voice_start_reg <= 1'b1;
              voice_on_reg    <= 1'b1;
            end else begin
              voice_on_reg <= 1'b0;
            end
          end
          ST_ISSUE: begin
            rr_last_reg  <= voice_sel_reg;
            state_reg    <= ST_HOLD;
            cnt_reg      <= HOLD_LOAD;
            voice_on_reg <= 1'b1;
          end
          ST_HOLD: begin
            cnt_reg      <= cnt_reg - CNT_ONE;
            voice_on_reg <= 1'b1;
          end
          ST_GAP: begin
            voice_on_reg <= 1'b0;
            if (cnt_reg == '0) begin
              state_reg <= ST_IDLE;
            end else begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end
          end
          default: begin
            state_reg    <= ST_IDLE;
            voice_on_reg <= 1'b0;
          end
        endcase
        // End of the note's last on-cycle. These assignments override the
        // HOLD/ISSUE updates above. With no gap, this cycle also serves as
        // the arbitration cycle.
        if (note_last) begin
          cnt_reg <= GAP_LOAD;
          if (GAP_LEN >= 2) begin
            state_reg    <= ST_GAP;
            voice_on_reg <= 1'b0;
          end else if ((GAP_LEN == 1) || !can_issue) begin
            state_reg    <= ST_IDLE;
            voice_on_reg <= 1'b0;
          end else begin
            state_reg       <= ST_ISSUE;
            voice_sel_reg   <= winner_idx;
            voice_start_reg <= 1'b1;
            voice_on_reg    <= 1'b1;
          end
        end
      end
    end
  end

  assign voice_start = voice_start_reg;
  assign voice_sel   = voice_sel_reg;
  assign voice_on    = voice_on_reg;
  assign pending     = pending_reg;
  assign drop        = drop_reg;

endmodule

// File: tb/tb_drum_voice_arbiter.sv
// tb_drum_voice_arbiter
//
// Self-checking bench for drum_voice_arbiter with NOTE_LEN=4 and GAP_LEN=2.
// Inputs change on the falling edge. Outputs are compared on the next
// falling edge.
//
// The reference model tracks each note by its age, counted in cycles since
// the start strobe:
//   - a note is sounding while age < NOTE_LEN;
//   - arbitration is allowed once age >= NOTE_LEN + GAP_LEN - 1.
// It uses a plain round-robin search over the pending bits.
module tb_drum_voice_arbiter;

  localparam int NOTE_LEN = 4;
  localparam int GAP_LEN  = 2;
  localparam int AGE_IDLE = 1000;

  logic       Clk;
  logic       Reset_n;
  logic       playing;
  logic [4:0] req;
  logic       voice_ready;
  logic       voice_start;
  logic [2:0] voice_sel;
  logic       voice_on;
  logic [4:0] pending;
  logic       drop;

  drum_voice_arbiter #(
    .NOTE_LEN(NOTE_LEN),
    .GAP_LEN (GAP_LEN),
    .CNT_W   (8)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .playing    (playing),
    .req        (req),
    .voice_ready(voice_ready),
    .voice_start(voice_start),
    .voice_sel  (voice_sel),
    .voice_on   (voice_on),
    .pending    (pending),
    .drop       (drop)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state.
  int         m_age;
  int         m_rr;
  int         m_sel;
  logic [4:0] m_pend;
  logic       m_start;
  logic       m_on;
  logic       m_drop;

  typedef struct packed {
    logic       play;
    logic [4:0] rq;
    logic       rdy;
    logic       start;
    logic [2:0] sel;
    logic       on;
    logic [4:0] pend;
    logic       drp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic p, input logic [4:0] r, input logic rdy,
                              input logic s, input logic [2:0] sl, input logic o,
                              input logic [4:0] pd, input logic dr);
    vec_t v;
    v.play  = p;
    v.rq    = r;
    v.rdy   = rdy;
    v.start = s;
    v.sel   = sl;
    v.on    = o;
    v.pend  = pd;
    v.drp   = dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age   = AGE_IDLE;
    m_rr    = 4;
    m_sel   = 0;
    m_pend  = '0;
    m_start = 1'b0;
    m_on    = 1'b0;
    m_drop  = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic [4:0] r, input logic rdy);
    int         thresh;
    int         win;
    int         idx;
    logic [4:0] base;
    thresh = NOTE_LEN + GAP_LEN - 1;
    if (!p) begin
      m_pend  = '0;
      m_drop  = 1'b0;
      m_start = 1'b0;
      m_on    = 1'b0;
      m_age   = AGE_IDLE;
      return;
    end
    base = m_pend;
    if (m_age == 0) begin
      base[m_sel] = 1'b0;
      m_rr        = m_sel;
    end
    m_drop = |(r & base);
    win    = -1;
    if (m_age >= thresh) begin
      for (int k = 1; k <= 5; k++) begin
        idx = (m_rr + k) % 5;
        if (win < 0 && base[idx]) win = idx;
      end
    end
`ifdef KICK_PREEMPT_EN
    if (base[0] && (m_age >= thresh || (m_age >= 1 && m_sel != 0))) win = 0;
`endif
    if (win >= 0 && rdy) begin
      m_sel   = win;
      m_age   = 0;
      m_start = 1'b1;
    end else begin
      m_start = 1'b0;
      if (m_age < AGE_IDLE) m_age++;
    end
    m_on   = (m_age < NOTE_LEN);
    m_pend = base | r;
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model,
  // then return on the falling edge where outputs are stable.
  task automatic cycle(input logic p, input logic [4:0] r, input logic rdy);
    playing     = p;
    req         = r;
    voice_ready = rdy;
    @(posedge Clk);
    model_step(p, r, rdy);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset_n     = 1'b0;
    playing     = 1'b0;
    req         = 5'd0;
    voice_ready = 1'b1;
    repeat (2) @(negedge Clk);
    model_reset();
    Reset_n = 1'b1;
  endtask

  int   s_cyc[$];
  int   s_sel[$];
  logic seen;
  logic seen_on;

  initial begin
    Reset_n     = 1'b0;
    playing     = 1'b0;
    req         = 5'd0;
    voice_ready = 1'b1;
    model_reset();

    // Reset state, observed while reset is held.
    @(negedge Clk);
    chk("reset voice_start", voice_start, 0);
    chk("reset voice_sel", voice_sel, 0);
    chk("reset voice_on", voice_on, 0);
    chk("reset pending", pending, 0);
    chk("reset drop", drop, 0);

    // Table: single hit on C, merged repeat hit on B, hit during B's own
    // ISSUE cycle, then abort. Each row gives the outputs after its edge.
    tbl.push_back(mk(1, 5'b00100, 1, 0, 0, 0, 5'b00100, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 1, 2, 1, 5'b00100, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 2, 1, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 2, 1, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 2, 1, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 2, 0, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 2, 0, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 2, 0, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00010, 1, 0, 2, 0, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00010, 0, 0, 2, 0, 5'b00010, 1));
    tbl.push_back(mk(1, 5'b00000, 1, 1, 1, 1, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00010, 1, 0, 1, 1, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 1, 1, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 1, 1, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 1, 0, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 1, 0, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 1, 1, 1, 5'b00010, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 1, 1, 5'b00000, 0));
    tbl.push_back(mk(0, 5'b00001, 1, 0, 1, 0, 5'b00000, 0));
    tbl.push_back(mk(1, 5'b00000, 1, 0, 1, 0, 5'b00000, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].play, tbl[i].rq, tbl[i].rdy);
      $display("vec %0d: start=%0d sel=%0d on=%0d pend=%b drop=%0d",
               i, voice_start, voice_sel, voice_on, pending, drop);
      chk($sformatf("vec%0d voice_start", i), voice_start, tbl[i].start);
      chk($sformatf("vec%0d voice_sel", i), voice_sel, tbl[i].sel);
      chk($sformatf("vec%0d voice_on", i), voice_on, tbl[i].on);
      chk($sformatf("vec%0d pending", i), pending, tbl[i].pend);
      chk($sformatf("vec%0d drop", i), drop, tbl[i].drp);
    end

    // Asynchronous reset in the middle of a note.
    do_reset();
    cycle(1, 5'b01010, 1);
    cycle(1, 5'b00000, 1);
    cycle(1, 5'b00000, 1);
    chk("t1 hold voice_on", voice_on, 1);
    chk("t1 hold pending", pending, 5'b01000);
    #2 Reset_n = 1'b0;
    #1;
    $display("t1 async reset: start=%0d sel=%0d on=%0d pend=%b drop=%0d",
             voice_start, voice_sel, voice_on, pending, drop);
    chk("t1 async voice_start", voice_start, 0);
    chk("t1 async voice_sel", voice_sel, 0);
    chk("t1 async voice_on", voice_on, 0);
    chk("t1 async pending", pending, 0);
    @(negedge Clk);
    model_reset();
    Reset_n = 1'b1;
    cycle(1, 5'b00001, 1);
    chk("t1 pending after release", pending, 5'b00001);
    cycle(1, 5'b00000, 1);
    chk("t1 first start", voice_start, 1);
    chk("t1 first sel", voice_sel, 0);

    // Simultaneous hits from reset are served 0, 1, 4, every 6 cycles.
    do_reset();
    s_cyc.delete();
    s_sel.delete();
    seen = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      cycle(1, (c == 0) ? 5'b10011 : 5'b00000, 1);
      if (voice_start === 1'b1) begin
        s_cyc.push_back(c);
        s_sel.push_back(int'(voice_sel));
        $display("t3 start at cycle %0d sel=%0d", c, voice_sel);
      end
      if (drop !== 1'b0) seen = 1'b1;
    end
    chk("t3 start count", s_cyc.size(), 3);
    if (s_cyc.size() == 3) begin
      chk("t3 sel0", s_sel[0], 0);
      chk("t3 sel1", s_sel[1], 1);
      chk("t3 sel2", s_sel[2], 4);
      chk("t3 first start cycle", s_cyc[0], 1);
      chk("t3 spacing1", s_cyc[1] - s_cyc[0], 6);
      chk("t3 spacing2", s_cyc[2] - s_cyc[1], 6);
    end
    chk("t3 drop never", seen, 0);

    // The engine is busy for 10 cycles; the start follows the ready edge.
    seen = 1'b0;
    cycle(1, 5'b01000, 0);
    if (voice_start !== 1'b0) seen = 1'b1;
    for (int c = 0; c < 9; c++) begin
      cycle(1, 5'b00000, 0);
      if (voice_start !== 1'b0) seen = 1'b1;
    end
    chk("t5 no start while busy", seen, 0);
    chk("t5 pending held", pending, 5'b01000);
    cycle(1, 5'b00000, 1);
    $display("t5 ready rise: start=%0d sel=%0d", voice_start, voice_sel);
    chk("t5 start after ready", voice_start, 1);
    chk("t5 sel", voice_sel, 3);

    // A kick hit arrives during channel 3's note.
    cycle(1, 5'b00001, 1);
    chk("t6 pending kick", pending, 5'b00001);
`ifdef KICK_PREEMPT_EN
    cycle(1, 5'b00000, 1);
    $display("t6 preempt: start=%0d sel=%0d", voice_start, voice_sel);
    chk("t6 preempt start", voice_start, 1);
    chk("t6 preempt sel", voice_sel, 0);
    cycle(0, 5'b00000, 1);
    chk("t6 abort voice_on", voice_on, 0);
    chk("t6 abort pending", pending, 0);
`else
    cycle(1, 5'b00000, 1);
    chk("t6 still holding", voice_on, 1);
    chk("t6 no preempt start", voice_start, 0);
    cycle(0, 5'b00000, 1);
    $display("t6 abort: start=%0d on=%0d pend=%b sel=%0d",
             voice_start, voice_on, pending, voice_sel);
    chk("t6 abort voice_on", voice_on, 0);
    chk("t6 abort pending", pending, 0);
    chk("t6 abort sel kept", voice_sel, 3);
    seen    = 1'b0;
    seen_on = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle(1, 5'b00000, 1);
      if (voice_start !== 1'b0) seen = 1'b1;
      if (voice_on !== 1'b0) seen_on = 1'b1;
    end
    chk("t6 no start after abort", seen, 0);
    chk("t6 silent after abort", seen_on, 0);
`endif

    // Randomized traffic compared against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic       p;
      logic [4:0] r;
      logic       rdy;
      p   = ($urandom_range(0, 39) != 0);
      rdy = ($urandom_range(0, 5) != 0);
      for (int b = 0; b < 5; b++) r[b] = ($urandom_range(0, 7) == 0);
      cycle(p, r, rdy);
      if (m_start) $display("rand note cycle %0d: ch=%0d", c, m_sel);
      chk("rand voice_start", voice_start, m_start);
      chk("rand voice_sel", voice_sel, m_sel);
      chk("rand voice_on", voice_on, m_on);
      chk("rand pending", pending, m_pend);
      chk("rand drop", drop, m_drop);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
